// File: rtl/hs_npu_requant_pipe.sv
// Per-lane requantisation: bias add, rounding arithmetic shift, saturate and activate.
// Three register stages share one stall enable derived from the output handshake.
module hs_npu_requant_pipe #(
    parameter int unsigned LANES       = 8,
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         cfg_load,
    input  logic [IN_WIDTH*LANES-1:0]    bias_i,
    input  logic [SHIFT_WIDTH*LANES-1:0] shift_i,
    input  logic                         round_en,
    input  logic [1:0]                   act_mode,
    input  logic [OUT_WIDTH-1:0]         clamp_max,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH*LANES-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH*LANES-1:0]   out_data,
    output logic [15:0]                  sat_count,
    output logic [15:0]                  beat_count
);
    localparam int unsigned SW = IN_WIDTH + 1;
    localparam int unsigned RW = IN_WIDTH + 2;
    localparam logic signed [RW-1:0] MaxV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MinV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH-1:0] bias_q  [LANES];
    logic [SHIFT_WIDTH-1:0]     shift_q [LANES];

    logic                       adv;
    logic                       deliver;

    logic                       s1_valid_q;
    logic signed [SW-1:0]       s1_sum_q   [LANES];
    logic signed [SW-1:0]       s1_sum_d   [LANES];
    logic [SHIFT_WIDTH-1:0]     s1_shift_q [LANES];
    logic                       s1_round_q;
    logic [1:0]                 s1_mode_q;
    logic [OUT_WIDTH-1:0]       s1_clamp_q;

    logic                       s2_valid_q;
    logic [RW-1:0]              rnd_inc    [LANES];
    logic signed [RW-1:0]       s2_val_q   [LANES];
    logic signed [RW-1:0]       s2_val_d   [LANES];
    logic [1:0]                 s2_mode_q;
    logic [OUT_WIDTH-1:0]       s2_clamp_q;

    logic                       s3_valid_q;
    logic [OUT_WIDTH-1:0]       clip       [LANES];
    logic [OUT_WIDTH-1:0]       s3_data_q  [LANES];
    logic [OUT_WIDTH-1:0]       s3_data_d  [LANES];
    logic [LANES-1:0]           s3_sat_q;
    logic [LANES-1:0]           s3_sat_d;

    assign adv       = !s3_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_valid_q;
    assign deliver   = s3_valid_q && out_ready;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data[i*OUT_WIDTH +: OUT_WIDTH] = s3_data_q[i];
        end
    end

    // S1: widen by one bit so the bias add cannot overflow.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_sum_d[i] = $signed({in_data[i*IN_WIDTH+IN_WIDTH-1], in_data[i*IN_WIDTH +: IN_WIDTH]})
                        + $signed({bias_q[i][IN_WIDTH-1], bias_q[i]});
        end
    end

    // S2: round-half-up adds 2^(sh-1) before the arithmetic shift.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rnd_inc[i] = '0;
            if (s1_round_q && (s1_shift_q[i] != '0)) begin
                rnd_inc[i] = {{(RW-1){1'b0}}, 1'b1} << (s1_shift_q[i] - SHIFT_WIDTH'(1));
            end
            s2_val_d[i] = ($signed({s1_sum_q[i][SW-1], s1_sum_q[i]}) + $signed(rnd_inc[i]))
                          >>> s1_shift_q[i];
        end
    end

    // S3: saturation flags only the range clamp, never the activation.
    always_comb begin
        s3_sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s2_val_q[i] > MaxV) begin
                clip[i]     = MaxV[OUT_WIDTH-1:0];
                s3_sat_d[i] = 1'b1;
            end else if (s2_val_q[i] < MinV) begin
                clip[i]     = MinV[OUT_WIDTH-1:0];
                s3_sat_d[i] = 1'b1;
            end else begin
                clip[i]     = s2_val_q[i][OUT_WIDTH-1:0];
            end
            s3_data_d[i] = clip[i];
            case (s2_mode_q)
                2'd1: if (clip[i][OUT_WIDTH-1]) s3_data_d[i] = '0;
                2'd2: begin
                    if (clip[i][OUT_WIDTH-1]) s3_data_d[i] = '0;
                    else if (clip[i] > s2_clamp_q) s3_data_d[i] = s2_clamp_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                bias_q[i]  <= '0;
                shift_q[i] <= '0;
            end
        end else if (cfg_load) begin
            for (int i = 0; i < LANES; i++) begin
                bias_q[i]  <= bias_i[i*IN_WIDTH +: IN_WIDTH];
                shift_q[i] <= shift_i[i*SHIFT_WIDTH +: SHIFT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_round_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_clamp_q <= '0;
            s2_mode_q  <= '0;
            s2_clamp_q <= '0;
            s3_sat_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_sum_q[i]   <= '0;
                s1_shift_q[i] <= '0;
                s2_val_q[i]   <= '0;
                s3_data_q[i]  <= '0;
            end
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s1_round_q <= round_en;
            s1_mode_q  <= act_mode;
            s1_clamp_q <= clamp_max;
            s2_mode_q  <= s1_mode_q;
            s2_clamp_q <= s1_clamp_q;
            s3_sat_q   <= s3_sat_d;
            for (int i = 0; i < LANES; i++) begin
                s1_sum_q[i]   <= s1_sum_d[i];
                s1_shift_q[i] <= shift_q[i];
                s2_val_q[i]   <= s2_val_d[i];
                s3_data_q[i]  <= s3_data_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count  <= '0;
            beat_count <= '0;
        end else if (flush) begin
            sat_count  <= '0;
            beat_count <= '0;
        end else if (deliver) begin
            beat_count <= beat_count + 16'd1;
            if ((|s3_sat_q) && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hs_npu_requant_pipe.sv
// Directed-vector bench for hs_npu_requant_pipe with hand-computed expectations.
module tb_hs_npu_requant_pipe;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         cfg_load;
    logic [255:0] bias_i;
    logic [39:0]  shift_i;
    logic         round_en;
    logic [1:0]   act_mode;
    logic [15:0]  clamp_max;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  sat_count;
    logic [15:0]  beat_count;

    logic signed [31:0] din [8];
    logic signed [31:0] bsv [8];
    logic [4:0]         shv [8];
    logic [15:0]        dout [8];
    logic [15:0]        res [4];
    int total = 0;
    int bad = 0;
    int exp_beats = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            in_data[j*32 +: 32] = din[j];
            bias_i[j*32 +: 32]  = bsv[j];
            shift_i[j*5 +: 5]   = shv[j];
        end
    end

    hs_npu_requant_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_load(cfg_load), .bias_i(bias_i),
        .shift_i(shift_i), .round_en(round_en), .act_mode(act_mode), .clamp_max(clamp_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sat_count(sat_count),
        .beat_count(beat_count)
    );

    function automatic logic [15:0] lane(input int j);
        return out_data[j*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int v);
        for (int j = 0; j < 8; j++) din[j] = v;
    endtask

    task automatic cfg_all(input int b, input int s);
        for (int j = 0; j < 8; j++) begin
            bsv[j] = b;
            shv[j] = 5'(s);
        end
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // One beat in, wait (bounded) for it, capture lanes, let it be delivered.
    task automatic push_one();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        check("push_timeout", 16'(out_valid), 16'd1);
        for (int j = 0; j < 8; j++) dout[j] = lane(j);
        @(posedge clk); #1;
        exp_beats++;
    endtask

    initial begin
        int sent, rcv, cyc, k;
        logic acc, stalled_prev;
        logic [15:0] prev0;
        logic seen;

        rst_n = 1'b0; flush = 1'b0; cfg_load = 1'b0; round_en = 1'b0; act_mode = 2'd0;
        clamp_max = 16'd0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0);
        for (int j = 0; j < 8; j++) begin bsv[j] = 0; shv[j] = 5'd0; end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ov", 16'(out_valid), 16'd0);
        check("rst_rdy", 16'(in_ready), 16'd1);
        check("rst_sat", sat_count, 16'd0);
        check("rst_beat", beat_count, 16'd0);
        check("rst_data", lane(5), 16'd0);

        // Basic: (100 + 10) >> 2 = 27, exact 3-cycle latency.
        cfg_all(10, 2);
        set_in(100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_c1", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        check("lat_c2", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        check("lat_c3", 16'(out_valid), 16'd1);
        check("basic_l0", lane(0), 16'd27);
        check("basic_l7", lane(7), 16'd27);
        @(posedge clk); #1;
        exp_beats++;
        check("basic_beat", beat_count, 16'd1);
        check("basic_ov", 16'(out_valid), 16'd0);

        // Per-lane config: (j*100 + 256) >> j, truncating.
        for (int j = 0; j < 8; j++) begin bsv[j] = j * 100; shv[j] = 5'(j); end
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        set_in(256);
        push_one();
        check("lane_l0", dout[0], 16'd256);
        check("lane_l3", dout[3], 16'd69);
        check("lane_l7", dout[7], 16'd7);

        // Rounding and sign.
        cfg_all(0, 1);
        for (int j = 0; j < 8; j += 4) begin
            din[j] = 3; din[j+1] = -3; din[j+2] = 5; din[j+3] = -5;
        end
        round_en = 1'b1;
        push_one();
        check("rnd_p3", dout[0], 16'd2);
        check("rnd_m3", dout[1], 16'hFFFF);
        check("rnd_p5", dout[2], 16'd3);
        check("rnd_m5", dout[7], 16'hFFFE);
        round_en = 1'b0;
        push_one();
        check("trn_p3", dout[4], 16'd1);
        check("trn_m3", dout[5], 16'hFFFE);
        check("trn_p5", dout[6], 16'd2);
        check("trn_m5", dout[3], 16'hFFFD);

        // Saturation and activation.
        cfg_all(0, 0);
        set_in(40000);
        push_one();
        check("sat_pos", dout[0], 16'h7FFF);
        check("sat_cnt1", sat_count, 16'd1);
        set_in(-40000); act_mode = 2'd1;
        push_one();
        check("sat_relu", dout[2], 16'd0);
        check("sat_cnt2", sat_count, 16'd2);
        set_in(9);
        push_one();
        check("relu_pos", dout[1], 16'd9);
        set_in(500); act_mode = 2'd2; clamp_max = 16'd255;
        push_one();
        check("clamp_hi", dout[4], 16'd255);
        check("clamp_cnt", sat_count, 16'd2);
        set_in(-7);
        push_one();
        check("clamp_neg", dout[4], 16'd0);
        set_in(500); clamp_max = 16'hFFFF;
        push_one();
        check("clamp_wide", dout[0], 16'd500);
        set_in(40000);
        push_one();
        check("clamp_sat", dout[0], 16'h7FFF);
        check("clamp_satc", sat_count, 16'd3);
        set_in(-7); act_mode = 2'd3;
        push_one();
        check("mode3", dout[6], 16'hFFF9);
        act_mode = 2'd0;

        // Wide sum: (2^32-2) >> 17 stays in range; rounding pushes it to 32768.
        cfg_all(32'h7FFFFFFF, 17);
        set_in(32'h7FFFFFFF);
        push_one();
        check("wide_trn", dout[0], 16'h7FFF);
        check("wide_trnc", sat_count, 16'd3);
        round_en = 1'b1;
        push_one();
        check("wide_rnd", dout[0], 16'h7FFF);
        check("wide_rndc", sat_count, 16'd4);
        round_en = 1'b0;
        check("beats_a", beat_count, 16'(exp_beats));

        // Backpressure: 10 back-to-back beats, out_ready pattern 1,0,0,1.
        cfg_all(0, 0);
        sent = 0; rcv = 0; cyc = 0; stalled_prev = 1'b0; prev0 = '0;
        while (rcv < 10 && cyc < 80) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 10);
            for (int j = 0; j < 8; j++) din[j] = 1000 + 16 * sent + j;
            #1;
            check("bp_ready", 16'(in_ready), 16'(!(out_valid && !out_ready)));
            if (stalled_prev) begin
                check("bp_hold_v", 16'(out_valid), 16'd1);
                check("bp_hold_d", lane(0), prev0);
            end
            if (out_valid && out_ready) begin
                check("bp_ord_l0", lane(0), 16'(1000 + 16 * rcv));
                check("bp_ord_l7", lane(7), 16'(1007 + 16 * rcv));
                rcv++;
            end
            acc = in_valid && in_ready;
            stalled_prev = out_valid && !out_ready;
            prev0 = lane(0);
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 16'(rcv), 16'd10);
        exp_beats += 10;
        check("beats_b", beat_count, 16'(exp_beats));

        // Config hazard: A accepted with cfg_load uses old bias 0, B uses 1000.
        for (int j = 0; j < 8; j++) bsv[j] = 1000;
        cfg_load = 1'b1; set_in(5); in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        for (int n = 0; n < 10; n++) begin
            if (out_valid && k < 4) begin res[k] = lane(0); k++; end
            @(posedge clk); #1;
        end
        check("hz_count", 16'(k), 16'd2);
        check("hz_a", res[0], 16'd5);
        check("hz_b", res[1], 16'd1005);

        // Flush with beats in flight, third beat accepted in the flush cycle.
        cfg_all(0, 0);
        set_in(1); in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_sat", sat_count, 16'd0);
        check("fl_beat", beat_count, 16'd0);
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("fl_noout", 16'(seen), 16'd0);
        set_in(2); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("fl_lat2", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        check("fl_lat3", 16'(out_valid), 16'd1);
        check("fl_data", lane(3), 16'd2);
        @(posedge clk); #1;
        check("fl_beat1", beat_count, 16'd1);

        // Asynchronous reset mid-stream; config returns to zero.
        cfg_all(50, 1);
        set_in(3); in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rs_pre_ov", 16'(out_valid), 16'd1);
        check("rs_pre_d", lane(0), 16'd26);
        #2 rst_n = 1'b0;
        #1;
        check("rs_ov", 16'(out_valid), 16'd0);
        check("rs_data", lane(0), 16'd0);
        check("rs_beat", beat_count, 16'd0);
        check("rs_rdy", 16'(in_ready), 16'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rs_noout", 16'(seen), 16'd0);
        set_in(77);
        push_one();
        check("rs_cfg0", dout[2], 16'd77);
        check("rs_beat1", beat_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hs_npu_requant_pipe.md
# hs_npu_requant_pipe

Pipelined, backpressure-aware post-processing stage for the NPU inference datapath. It sits between the matrix-multiply unit column outputs and the output FIFOs. Per lane it adds a bias, applies a rounding arithmetic right shift, saturates to the output width and applies a selectable activation. Unlike the single-cycle accumulate/activate path, it carries per-lane bias and shift, supports round-to-nearest, ReLU and clamp modes, valid/ready stalling, flush, and saturation/beat counters.

## Interface
- LANES, 8, number of parallel channels (columns)
- IN_WIDTH, 32, signed accumulator input width
- OUT_WIDTH, 16, signed output width; OUT_WIDTH < IN_WIDTH
- SHIFT_WIDTH, 5, width of per-lane shift amount

- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; drops all in-flight beats and clears counters
- cfg_load  input  1  latch bias_i/shift_i into per-lane config registers
- bias_i  input  IN_WIDTH x LANES  signed per-lane bias
- shift_i  input  SHIFT_WIDTH x LANES  per-lane right-shift amount
- round_en  input  1  1 = round half up before shift, 0 = truncate (floor)
- act_mode  input  2  0 none, 1 ReLU, 2 clamp [0, clamp_max], 3 treated as 0
- clamp_max  input  OUT_WIDTH  unsigned upper bound for mode 2
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  IN_WIDTH x LANES  signed accumulator values
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready
- out_data  output  OUT_WIDTH x LANES  signed results
- sat_count  output  16  beats with at least one lane saturated, saturating counter
- beat_count  output  16  beats delivered (out_valid && out_ready), wrapping counter

## Operation
- Config registers: bias_reg[i], shift_reg[i] reset to 0; on cfg_load they take bias_i/shift_i at the clock edge. A beat accepted in the same cycle as cfg_load uses the old values.
- act_mode, round_en and clamp_max are sampled when a beat enters S1 and are carried with the beat. shift_reg is also carried with the beat. Config changes never affect beats already in flight.
- S1 (add): sum = sext(in_data[i]) + sext(bias_reg[i]), IN_WIDTH+1 bits, no overflow.
- S2 (shift): if round_en and sh>0, add 1<<(sh-1) first (IN_WIDTH+2 bits). Then arithmetic right shift by sh. Example: -3 with sh=1 rounds to -1; 3 with sh=1 rounds to 2.
- S3 (saturate/activate):
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set lane_sat if clamping occurred.
  - Mode 1: negative results become 0.
  - Mode 2: results become min(max(x,0), clamp_max). clamp_max above the positive limit behaves as the positive limit.
  - ReLU and clamp do not set lane_sat.
- sat_count increments by 1 per delivered beat whose OR(lane_sat) is 1, and holds at 0xFFFF. beat_count wraps at 0xFFFF→0.
- flush: clears all stage valid bits and both counters. Config registers are kept. Any handshake in that cycle is discarded. flush has priority over everything except reset.

## Timing
- Three register stages; latency from accepted input to out_valid is 3 cycles when unstalled. Throughput is 1 beat/cycle.
- Stall uses a global enable: adv = !out_valid || out_ready. in_ready = adv. All stages shift only when adv=1.
- Bubbles are not compressed.
- in_ready is combinational from out_valid/out_ready only, never from in_valid.
- out_data and out_valid are driven directly from S3 registers. out_data holds stable while out_valid && !out_ready.
- Reset values: out_valid 0, out_data all 0, sat_count 0, beat_count 0, all stage valids 0. in_ready is 1 after reset.
- Reset mid-stream: all in-flight beats are lost and no partial output is produced.
- A beat accepted in the flush cycle is dropped. The first beat after flush appears 3 cycles after its acceptance.

## Test plan
- Basic: bias=10, shift=2, round_en=0, mode 0; in=100 on all lanes → out=27 after exactly 3 cycles; beat_count=1.
- Rounding and sign: shift=1, round_en=1, bias=0; in lanes {3,-3,5,-5} → {2,-1,3,-2}; with round_en=0 → {1,-2,2,-3}.
- Saturation and activation: OUT_WIDTH=16, shift=0, in=40000 → 32767 and sat_count=1. Same with in=-40000 and mode 1 → 0 and sat_count=2. in=500 with mode 2, clamp_max=255 → 255 and sat_count unchanged.
- Backpressure: stream 10 back-to-back beats while out_ready toggles 1,0,0,1 → all 10 delivered in order, none duplicated; out_data is stable during stalls; in_ready=0 exactly when out_valid && !out_ready.
- Config hazard: cfg_load with bias 0→1000 in the same cycle as accepting beat A, then beat B next cycle → A uses bias 0, B uses 1000.
- Flush/reset: flush with 3 beats in flight → no out_valid for those beats, counters read 0. Assert rst_n low mid-stream → out_valid drops asynchronously to 0.
